spi_secondary: RTL and testbench

Clock-synchronous SPI secondary (peripheral) endpoint, the far end of the link driven by `spi_core`. It oversamples `sclk`, `cs` and `mosi` on the system clock, shifts a received word in MSB-first, and shifts a preloaded word out on `miso`. A parallel load/read handshake with a `done` strobe connects it to local logic.

---
 rtl/spi_pkg.sv | 15 +
 rtl/spi_sync.sv | 33 +++
 rtl/spi_secondary.sv | 188 ++++++++++++++++++
 tb/tb_spi_secondary.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI secondary endpoint.
//   SPI_SEC_DWIDTH  : default word length in bits
//   SPI_SYNC_STAGES : flops per input synchronizer
//   spi_sec_state_t : secondary FSM states
package spi_pkg;

    localparam int SPI_SEC_DWIDTH  = 8;
    localparam int SPI_SYNC_STAGES = 2;

    typedef enum logic {
        SPI_SEC_IDLE  = 1'b0,
        SPI_SEC_SHIFT = 1'b1
    } spi_sec_state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Ports:
//   clk : system clock
//   rst : asynchronous reset, active-low
//   d   : asynchronous input
//   q   : synchronized output (SPI_SYNC_STAGES clk of latency)
// RESET_VAL sets the value the chain holds in reset, so an idle-high
// input does not produce a false edge when reset is released.
module spi_sync
    import spi_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SPI_SYNC_STAGES-1:0] stages;

    // Shift the input through the flop chain; the last flop is the output.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stages <= {SPI_SYNC_STAGES{RESET_VAL}};
        end else begin
            stages <= {stages[SPI_SYNC_STAGES-2:0], d};
        end
    end

    assign q = stages[SPI_SYNC_STAGES-1];

endmodule

// File: rtl/spi_secondary.sv
// SPI secondary endpoint, mode 0, MSB first, oversampled on clk.
// Ports:
//   clk, rst          : system clock, asynchronous active-low reset
//   sclk, cs, mosi    : SPI pins from the initiator (asynchronous)
//   miso              : serial data to the initiator
//   wr, din, tx_full  : TX buffer load handshake
//   rd, dout, rx_valid: RX word handshake
//   done              : one-cycle pulse per completed word
//   overrun           : sticky lost-word flag (only with SPI_SEC_OVERRUN_EN)
// Optional feature macro: SPI_SEC_OVERRUN_EN.
module spi_secondary
    import spi_pkg::*;
#(
    parameter int DWIDTH = SPI_SEC_DWIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sclk,
    input  logic              cs,
    input  logic              mosi,
    output logic              miso,
    input  logic              wr,
    input  logic [DWIDTH-1:0] din,
    output logic              tx_full,
    input  logic              rd,
    output logic [DWIDTH-1:0] dout,
    output logic              rx_valid,
    output logic              done
`ifdef SPI_SEC_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam int CNT_W = $clog2(DWIDTH + 1);

    logic sclk_s, cs_s, mosi_s;
    logic sclk_d, cs_d;
    logic sclk_rise, sclk_fall, cs_fall, cs_rise;

    spi_sec_state_t    state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DWIDTH-1:0] tx_sh;
    // The newest word's MSB leaves rx_sh the same cycle the word goes to
    // dout, so only DWIDTH-1 bits of history are kept.
    logic [DWIDTH-2:0] rx_sh;
    logic [DWIDTH-1:0] rx_next;
    logic [DWIDTH-1:0] tx_buf;
    logic [DWIDTH-1:0] load_word;
    logic              reload;
    logic              load_now;
    logic              take;
    logic              word_done;

    // cs idles high, so its synchronizer resets high to avoid a phantom select.
    spi_sync #(.RESET_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst(rst), .d(sclk), .q(sclk_s));
    spi_sync #(.RESET_VAL(1'b1)) u_sync_cs   (.clk(clk), .rst(rst), .d(cs),   .q(cs_s));
    spi_sync #(.RESET_VAL(1'b0)) u_sync_mosi (.clk(clk), .rst(rst), .d(mosi), .q(mosi_s));

    assign sclk_rise = sclk_s & ~sclk_d;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign cs_fall   = ~cs_s & cs_d;
    assign cs_rise   = cs_s & ~cs_d;

    assign load_word = tx_full ? tx_buf : '0;
    assign take      = load_now & tx_full;
    assign rx_next   = {rx_sh, mosi_s};
    assign miso      = tx_sh[DWIDTH-1];

    // Decode the cycles in which the TX shifter reloads from the buffer and
    // in which a received word completes; cs rising overrides both.
    always_comb begin
        load_now  = 1'b0;
        word_done = 1'b0;
        case (state)
            SPI_SEC_IDLE: begin
                load_now = cs_fall;
            end
            SPI_SEC_SHIFT: begin
                if (!cs_rise) begin
                    load_now  = sclk_fall & reload;
                    word_done = sclk_rise && (bit_cnt == CNT_W'(DWIDTH - 1));
                end
            end
            default: begin
                load_now  = 1'b0;
                word_done = 1'b0;
            end
        endcase
    end

    // Main FSM: edge-detect registers, shifters, bit counter and done.
    // miso is the TX shifter MSB, so it only moves when tx_sh is written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= SPI_SEC_IDLE;
            sclk_d  <= 1'b0;
            cs_d    <= 1'b1;
            bit_cnt <= '0;
            tx_sh   <= '0;
            rx_sh   <= '0;
            reload  <= 1'b0;
            dout    <= '0;
            done    <= 1'b0;
        end else begin
            sclk_d <= sclk_s;
            cs_d   <= cs_s;
            done   <= word_done;
            case (state)
                SPI_SEC_IDLE: begin
                    if (cs_fall) begin
                        tx_sh   <= load_word;
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                        state   <= SPI_SEC_SHIFT;
                    end
                end
                SPI_SEC_SHIFT: begin
                    if (cs_rise) begin
                        bit_cnt <= '0;
                        reload  <= 1'b0;
                        state   <= SPI_SEC_IDLE;
                    end else begin
                        if (sclk_rise) begin
                            rx_sh <= rx_next[DWIDTH-2:0];
                            if (word_done) begin
                                dout    <= rx_next;
                                bit_cnt <= '0;
                                reload  <= 1'b1;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                            end
                        end
                        if (sclk_fall) begin
                            if (reload) begin
                                tx_sh  <= load_word;
                                reload <= 1'b0;
                            end else begin
                                tx_sh <= {tx_sh[DWIDTH-2:0], 1'b0};
                            end
                        end
                    end
                end
                default: begin
                    state <= SPI_SEC_IDLE;
                end
            endcase
        end
    end

    // TX buffer: a take by the shifter beats a simultaneous write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_buf  <= '0;
            tx_full <= 1'b0;
        end else if (take) begin
            tx_full <= 1'b0;
        end else if (wr && !tx_full) begin
            tx_buf  <= din;
            tx_full <= 1'b1;
        end
    end

    // RX valid flag: a new word keeps it set even if rd arrives together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_valid <= 1'b0;
        end else if (word_done) begin
            rx_valid <= 1'b1;
        end else if (rd) begin
            rx_valid <= 1'b0;
        end
    end

`ifdef SPI_SEC_OVERRUN_EN
    // Sticky overrun: a word landed on top of one nobody consumed.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overrun <= 1'b0;
        end else if (word_done && rx_valid && !rd) begin
            overrun <= 1'b1;
        end else if (rd) begin
            overrun <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_spi_secondary.sv
// Testbench for spi_secondary: drives a mode-0 initiator with 8 clk per sclk
// period, keeps a behavioural model of the TX buffer and RX flags, and checks
// every done pulse against a scoreboard of expected received words.
// Honours SPI_SEC_OVERRUN_EN for the overrun port.
module tb_spi_secondary;

    localparam int DW = 8;

    logic          clk  = 1'b0;
    logic          rst  = 1'b1;
    logic          sclk = 1'b0;
    logic          cs   = 1'b1;
    logic          mosi = 1'b0;
    logic          wr   = 1'b0;
    logic          rd   = 1'b0;
    logic [DW-1:0] din  = '0;
    logic          miso;
    logic          tx_full;
    logic [DW-1:0] dout;
    logic          rx_valid;
    logic          done;
`ifdef SPI_SEC_OVERRUN_EN
    logic          overrun;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model state
    logic [7:0] dq[$];
    logic [7:0] mq[$];
    bit         exp_full = 1'b0;
    logic [7:0] exp_buf  = '0;
    bit         exp_rxv  = 1'b0;
    bit         exp_ovr  = 1'b0;
    bit         rd_flag  = 1'b0;

    spi_secondary #(.DWIDTH(DW)) dut (
        .clk(clk),
        .rst(rst),
        .sclk(sclk),
        .cs(cs),
        .mosi(mosi),
        .miso(miso),
        .wr(wr),
        .din(din),
        .tx_full(tx_full),
        .rd(rd),
        .dout(dout),
        .rx_valid(rx_valid),
        .done(done)
`ifdef SPI_SEC_OVERRUN_EN
        ,
        .overrun(overrun)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // The shifter takes the buffer (or zeros) at cs fall and at each reload.
    task automatic modelTake(output logic [7:0] w);
        w = exp_full ? exp_buf : 8'h00;
        exp_full = 1'b0;
    endtask

    task automatic doWrite(input logic [7:0] d);
        din = d;
        wr  = 1'b1;
        clks(1);
        wr  = 1'b0;
        if (!exp_full) begin
            exp_buf  = d;
            exp_full = 1'b1;
        end
    endtask

    task automatic doRead();
        rd = 1'b1;
        clks(1);
        rd = 1'b0;
        exp_rxv = 1'b0;
        exp_ovr = 1'b0;
    endtask

    task automatic checkState(input string tag);
        checkOutput({tag, "_tx_full"}, tx_full, exp_full);
        checkOutput({tag, "_rx_valid"}, rx_valid, exp_rxv);
`ifdef SPI_SEC_OVERRUN_EN
        checkOutput({tag, "_overrun"}, overrun, exp_ovr);
`endif
    endtask

    // One sclk period; miso is sampled just before the rising edge. With
    // rd_pulse, rd is placed on the clk edge where the word completes.
    task automatic bitCycle(input logic b, input bit rd_pulse, output logic m);
        mosi = b;
        clks(4);
        m    = miso;
        sclk = 1'b1;
        if (rd_pulse) begin
            clks(2);
            rd = 1'b1;
            rd_flag = 1'b1;
            clks(1);
            rd = 1'b0;
            clks(1);
        end else begin
            clks(4);
        end
        sclk = 1'b0;
    endtask

    // One cs window carrying n full words back to back.
    task automatic applyStimulus(input logic [7:0] words[4], input int n, input bit rd_last);
        logic [7:0] tw;
        logic [7:0] got;
        logic       m;
        cs = 1'b0;
        for (int w = 0; w < n; w++) begin
            modelTake(tw);
            mq.push_back(tw);
            dq.push_back(words[w]);
            got = '0;
            for (int i = 0; i < 8; i++) begin
                bitCycle(words[w][7-i], rd_last && (w == n - 1) && (i == 7), m);
                got = {got[6:0], m};
            end
            checkOutput("miso_word", got, mq.pop_front());
        end
        // The fall after the last word also reloads the shifter.
        modelTake(tw);
        clks(4);
        cs = 1'b1;
        clks(8);
        checkOutput("done_count", dq.size(), 0);
    endtask

    // Monitor: every done pulse consumes one expected word.
    always @(negedge clk) begin
        if (rst && done) begin
            if (dq.size() == 0) begin
                tests++;
                fails++;
                $display("[TB] FAIL done_unexpected: got done=1 expected done=0 at %0t", $time);
            end else begin
                checkOutput("dout", dout, dq.pop_front());
            end
            exp_ovr = rd_flag ? 1'b0 : (exp_ovr | exp_rxv);
            exp_rxv = 1'b1;
            rd_flag = 1'b0;
            checkOutput("rx_valid_on_done", rx_valid, 1);
`ifdef SPI_SEC_OVERRUN_EN
            checkOutput("overrun_on_done", overrun, exp_ovr);
`endif
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [7:0] words[4];
        logic [7:0] tw;
        logic       m;
        int         nw;

        #2 rst = 1'b0;
        clks(3);
        checkOutput("reset_miso", miso, 0);
        checkOutput("reset_dout", dout, 0);
        checkOutput("reset_done", done, 0);
        checkState("reset");
        rst = 1'b1;
        clks(3);

        $display("[TB] TX then word");
        doWrite(8'hA5);
        checkState("after_wr");
        words = '{8'h3C, 8'h00, 8'h00, 8'h00};
        applyStimulus(words, 1, 1'b0);
        checkState("tx_word");

        $display("[TB] empty buffer");
        words = '{8'hFF, 8'h00, 8'h00, 8'h00};
        applyStimulus(words, 1, 1'b0);
        checkState("empty");
        doRead();
        checkState("read1");

        $display("[TB] back-to-back");
        doWrite(8'hC7);
        words = '{8'h01, 8'h80, 8'h00, 8'h00};
        fork
            applyStimulus(words, 2, 1'b0);
            begin
                clks(24);
                doWrite(8'h5A);
            end
        join
        checkOutput("b2b_dout", dout, 8'h80);
        checkState("b2b");

        $display("[TB] abort");
        cs = 1'b0;
        modelTake(tw);
        for (int i = 0; i < 5; i++) bitCycle(1'($urandom), 1'b0, m);
        clks(4);
        cs = 1'b1;
        clks(8);
        checkOutput("abort_dout", dout, 8'h80);
        checkState("abort");

        $display("[TB] handshake edges");
        doWrite(8'h96);
        doWrite(8'h69);
        checkState("wr_full");
        words = '{8'($urandom), 8'h00, 8'h00, 8'h00};
        applyStimulus(words, 1, 1'b1);
        checkState("rd_with_done");

        $display("[TB] random traffic");
        for (int k = 0; k < 8; k++) begin
            if ($urandom_range(0, 1) == 1) doWrite(8'($urandom));
            if ($urandom_range(0, 1) == 1) doWrite(8'($urandom));
            nw = int'($urandom_range(1, 2));
            words = '{8'($urandom), 8'($urandom), 8'h00, 8'h00};
            applyStimulus(words, nw, 1'($urandom_range(0, 1)));
            checkState("rand");
            if ($urandom_range(0, 1) == 1) begin
                doRead();
                checkState("rand_rd");
            end
        end

        $display("[TB] reset mid-word");
        doWrite(8'h3E);
        cs = 1'b0;
        modelTake(tw);
        for (int i = 0; i < 3; i++) bitCycle(1'($urandom), 1'b0, m);
        rst = 1'b0;
        #2;
        checkOutput("midrst_miso", miso, 0);
        checkOutput("midrst_dout", dout, 0);
        checkOutput("midrst_done", done, 0);
        dq.delete();
        mq.delete();
        exp_full = 1'b0;
        exp_rxv  = 1'b0;
        exp_ovr  = 1'b0;
        rd_flag  = 1'b0;
        checkState("midrst");
        cs   = 1'b1;
        sclk = 1'b0;
        mosi = 1'b0;
        clks(3);
        rst = 1'b1;
        clks(3);
        words = '{8'hC3, 8'h00, 8'h00, 8'h00};
        applyStimulus(words, 1, 1'b0);
        checkOutput("post_rst_dout", dout, 8'hC3);
        checkState("post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
